// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared router parameters, port encoding and free-VC encoder
package noc_params;

   localparam int PORT_NUM = 5;
   localparam int VC_NUM   = 2;
   localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int PTR_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      EAST  = 3'd4
   } port_t;

   // Index of the lowest set bit; callers only use the result when mask != 0.
   function automatic logic [VC_SIZE-1:0] lowest_free(input logic [VC_NUM-1:0] mask);
      lowest_free = '0;
      for (int v = VC_NUM - 1; v >= 0; v--) begin
         if (mask[v]) lowest_free = VC_SIZE'(v);
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
   parameter int N = 5,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] request,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);

   int idx;

   // Scan from the farthest offset back to ptr so the closest hit overwrites the rest.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (request[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = W'(idx);
         end
      end
   end

endmodule

// File: rtl/vc_alloc_arbiter.sv
// rtl/vc_alloc_arbiter.sv - per-router VC allocator: round-robin per output, lowest free VC
module vc_alloc_arbiter
   import noc_params::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PORT_NUM-1:0]               vc_request,
   input  port_t [PORT_NUM-1:0]              out_port,
   input  logic [PORT_NUM-1:0]               release_valid,
   input  logic [PORT_NUM-1:0][VC_SIZE-1:0]  release_vc,
   output logic [PORT_NUM-1:0]               vc_valid,
   output logic [PORT_NUM-1:0][VC_SIZE-1:0]  vc_new,
   output logic [PORT_NUM-1:0][VC_NUM-1:0]   free_mask,
   output logic                              err_double_free
);

   logic [PORT_NUM-1:0][PTR_W-1:0]    rr_ptr;
   logic [PORT_NUM-1:0][PORT_NUM-1:0] port_req;
   logic [PORT_NUM-1:0][PORT_NUM-1:0] arb_grant;
   logic [PORT_NUM-1:0][PTR_W-1:0]    arb_idx;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]  free_idx;
   logic [PORT_NUM-1:0]               grant_ok;

   logic [PORT_NUM-1:0]               valid_d;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]  new_d;
   logic [PORT_NUM-1:0][VC_NUM-1:0]   mask_d;
   logic [PORT_NUM-1:0][PTR_W-1:0]    ptr_d;
   logic                              err_d;

   // Inputs showing a grant this cycle are masked so a held request is not served twice.
   always_comb begin
      port_req = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            port_req[o][i] = vc_request[i] && (out_port[i] == port_t'(o)) && !vc_valid[i];
         end
      end
   end

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
      rr_arbiter #(
         .N (PORT_NUM),
         .W (PTR_W)
      ) u_rr (
         .request   (port_req[o]),
         .ptr       (rr_ptr[o]),
         .grant     (arb_grant[o]),
         .grant_idx (arb_idx[o])
      );

      assign free_idx[o] = lowest_free(free_mask[o]);
      assign grant_ok[o] = (|arb_grant[o]) && (|free_mask[o]);
   end

   // Grant and release both work from the registered mask; a release only frees a busy VC,
   // so it can never collide with the VC granted in the same cycle.
   always_comb begin
      valid_d = '0;
      new_d   = vc_new;
      mask_d  = free_mask;
      ptr_d   = rr_ptr;
      err_d   = err_double_free;
      for (int o = 0; o < PORT_NUM; o++) begin
         if (grant_ok[o]) begin
            valid_d[arb_idx[o]]    = 1'b1;
            new_d[arb_idx[o]]      = free_idx[o];
            mask_d[o][free_idx[o]] = 1'b0;
            ptr_d[o] = (arb_idx[o] == PTR_W'(PORT_NUM - 1)) ? '0 : arb_idx[o] + PTR_W'(1);
         end
         if (release_valid[o]) begin
            if (free_mask[o][release_vc[o]]) begin
               err_d = 1'b1;
            end else begin
               mask_d[o][release_vc[o]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vc_valid        <= '0;
         vc_new          <= '0;
         free_mask       <= '1;
         rr_ptr          <= '0;
         err_double_free <= 1'b0;
      end else begin
         vc_valid        <= valid_d;
         vc_new          <= new_d;
         free_mask       <= mask_d;
         rr_ptr          <= ptr_d;
         err_double_free <= err_d;
      end
   end

endmodule
